// File: rtl/btb_lookup_pkg.sv
// btb_lookup_pkg: shared entry count, counter encodings and pipeline slot type
package btb_lookup_pkg;
  localparam int BTB_ENTRIES = 8;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } slot_t;
endpackage

// File: rtl/btb_lookup_match.sv
// btb_match: 8-way tag compare with lowest-index priority select
module btb_match
  import btb_lookup_pkg::*;
#(
  parameter int N = BTB_ENTRIES
) (
  input  logic [31:0]          pc,
  input  logic [N-1:0]         valid_i,
  input  logic [32*N-1:0]      tag_i,
  input  logic [32*N-1:0]      tgt_i,
  input  logic [2*N-1:0]       state_i,
  output logic                 hit,
  output logic [$clog2(N)-1:0] idx,
  output logic [31:0]          target,
  output ctr_e                 state
);
  localparam int IW = $clog2(N);
  // scan high to low so the lowest matching entry is the last to write
  always_comb begin
    hit = 1'b0;
    idx = '0;
    target = 32'h0;
    state = SNT;
    for (int i = N - 1; i >= 0; i--)
      if (valid_i[i] && tag_i[32*i +: 32] == pc && pc[1:0] == 2'b00) begin
        hit = 1'b1;
        idx = IW'(i);
        target = tgt_i[32*i +: 32];
        state = ctr_e'(state_i[2*i +: 2]);
      end
  end
endmodule

// File: rtl/btb_lookup.sv
// btb_lookup: fetch-side BTB read, next-PC prediction and IF/ID/EX prediction pipeline; BTB_STATS_EN enables statistics counters
module btb_lookup
  import btb_lookup_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pc_if,
  input  logic [ENTRIES-1:0]      valid_i,
  input  logic [32*ENTRIES-1:0]   tag_i,
  input  logic [32*ENTRIES-1:0]   tgt_i,
  input  logic [2*ENTRIES-1:0]    state_i,
  input  logic                    stall,
  input  logic                    flush,
  output logic [31:0]             pred_pc,
  output logic                    pred_hit,
  output logic                    pred_bs_id,
  output logic                    pred_bs_ex,
  output logic [31:0]             pred_tgt_ex,
  output logic [31:0]             stat_lookups,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_miss
);
  logic [$clog2(ENTRIES)-1:0] hit_idx;
  logic [31:0] hit_tgt;
  ctr_e hit_state;
  logic taken, unused_idx;
  slot_t ifid, idex;
  btb_match #(.N(ENTRIES)) u_match (
    .pc(pc_if), .valid_i(valid_i), .tag_i(tag_i), .tgt_i(tgt_i), .state_i(state_i),
    .hit(pred_hit), .idx(hit_idx), .target(hit_tgt), .state(hit_state)
  );
  assign unused_idx = ^hit_idx;
  assign taken = pred_hit && (hit_state == WT || hit_state == ST);
  assign pred_pc = taken ? hit_tgt : pc_if + 32'h4;
  assign pred_bs_id = ifid.taken;
  assign pred_bs_ex = idex.taken;
  assign pred_tgt_ex = idex.target;
  // prediction pipeline: reset > flush > stall > advance
  always_ff @(posedge clk)
    if (rst || flush) begin
      ifid <= '0;
      idex <= '0;
    end else if (!stall) begin
      ifid <= '{taken: taken, target: pred_pc};
      idex <= ifid;
    end
`ifdef BTB_STATS_EN
  // saturating statistics counters
  always_ff @(posedge clk)
    if (rst) begin
      stat_lookups <= 32'h0;
      stat_hits <= 32'h0;
      stat_miss <= 32'h0;
    end else begin
      if (!flush && !stall && stat_lookups != 32'hFFFFFFFF) stat_lookups <= stat_lookups + 32'h1;
      if (!flush && !stall && pred_hit && stat_hits != 32'hFFFFFFFF) stat_hits <= stat_hits + 32'h1;
      if (flush && stat_miss != 32'hFFFFFFFF) stat_miss <= stat_miss + 32'h1;
    end
`else
  assign stat_lookups = 32'h0;
  assign stat_hits = 32'h0;
  assign stat_miss = 32'h0;
`endif
endmodule

// File: tb/tb_btb_lookup.sv
// tb_btb_lookup: directed vector table plus pipeline/stall/flush sequences for btb_lookup
module tb_btb_lookup;
  logic clk = 1'b0, rst, stall, flush;
  logic [31:0] pc_if;
  logic [7:0] valid_i;
  logic [255:0] tag_i, tgt_i;
  logic [15:0] state_i;
  logic [31:0] pred_pc, pred_tgt_ex, stat_lookups, stat_hits, stat_miss;
  logic pred_hit, pred_bs_id, pred_bs_ex;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_pc;
    logic        exp_hit;
  } vec_t;
  vec_t vecs[7];
  logic [31:0] m0, l0, h0;
  logic [31:0] exp_d;

  btb_lookup dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .valid_i(valid_i), .tag_i(tag_i), .tgt_i(tgt_i),
    .state_i(state_i), .stall(stall), .flush(flush), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .pred_bs_id(pred_bs_id), .pred_bs_ex(pred_bs_ex), .pred_tgt_ex(pred_tgt_ex),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_e(input int n, input logic v, input logic [31:0] tag, input logic [31:0] tgt, input logic [1:0] st);
    valid_i[n-1] = v;
    tag_i[32*(n-1) +: 32] = tag;
    tgt_i[32*(n-1) +: 32] = tgt;
    state_i[2*(n-1) +: 2] = st;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    pc_if = 32'h00400000; valid_i = '0; tag_i = '0; tgt_i = '0; state_i = '0;
    tick(); tick();
    chk("rst_bs_id", 32'(pred_bs_id), 32'h0);
    chk("rst_bs_ex", 32'(pred_bs_ex), 32'h0);
    chk("rst_tgt_ex", pred_tgt_ex, 32'h0);
    chk("rst_lookups", stat_lookups, 32'h0);
    chk("rst_miss", stat_miss, 32'h0);
    chk("rst_pred_pc", pred_pc, 32'h00400004);
    rst = 1'b0;
    #1;
    chk("empty_hit", 32'(pred_hit), 32'h0);
    tick(); tick();
    chk("empty_bs_ex", 32'(pred_bs_ex), 32'h0);
    chk("empty_tgt_ex", pred_tgt_ex, 32'h00400004);

    set_e(3, 1'b1, 32'h00400010, 32'h00400040, 2'b11);
    set_e(2, 1'b1, 32'h00400020, 32'h00000100, 2'b10);
    set_e(6, 1'b1, 32'h00400020, 32'h00000200, 2'b10);
    set_e(5, 1'b1, 32'h00400030, 32'h00000999, 2'b01);
    set_e(7, 1'b0, 32'h00400050, 32'h00000777, 2'b11);
    set_e(8, 1'b1, 32'h00400012, 32'h00000888, 2'b11);
    vecs[0] = '{32'h00400000, 32'h00400004, 1'b0};
    vecs[1] = '{32'h00400010, 32'h00400040, 1'b1};
    vecs[2] = '{32'h00400020, 32'h00000100, 1'b1};
    vecs[3] = '{32'h00400030, 32'h00400034, 1'b1};
    vecs[4] = '{32'h00400050, 32'h00400054, 1'b0};
    vecs[5] = '{32'h00400012, 32'h00400016, 1'b0};
    vecs[6] = '{32'hFFFFFFFC, 32'h00000000, 1'b0};
    for (int i = 0; i < 7; i++) begin
      pc_if = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_pc", i), pred_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_hit", i), 32'(pred_hit), 32'(vecs[i].exp_hit));
    end

    pc_if = 32'h00400010;
    l0 = stat_lookups; h0 = stat_hits;
    tick();
    chk("taken_bs_id", 32'(pred_bs_id), 32'h1);
`ifdef BTB_STATS_EN
    exp_d = 32'h1;
`else
    exp_d = 32'h0;
`endif
    chk("stat_lookup_inc", stat_lookups - l0, exp_d);
    chk("stat_hit_inc", stat_hits - h0, exp_d);
    pc_if = 32'h00400000;
    tick();
    chk("taken_bs_ex", 32'(pred_bs_ex), 32'h1);
    chk("taken_tgt_ex", pred_tgt_ex, 32'h00400040);

    set_e(3, 1'b1, 32'h00400010, 32'h00400040, 2'b01);
    pc_if = 32'h00400010;
    #1;
    chk("wnt_hit", 32'(pred_hit), 32'h1);
    chk("wnt_pc", pred_pc, 32'h00400014);
    tick(); pc_if = 32'h00400000; tick();
    chk("wnt_bs_ex", 32'(pred_bs_ex), 32'h0);
    chk("wnt_tgt_ex", pred_tgt_ex, 32'h00400014);
    set_e(3, 1'b1, 32'h00400010, 32'h00400040, 2'b11);

    pc_if = 32'h00400000; tick(); tick();
    pc_if = 32'h00400010; tick();
    stall = 1'b1; pc_if = 32'h00400000; tick();
    chk("stall_bs_id", 32'(pred_bs_id), 32'h1);
    chk("stall_bs_ex", 32'(pred_bs_ex), 32'h0);
    stall = 1'b0; tick();
    chk("unstall_bs_ex", 32'(pred_bs_ex), 32'h1);

    pc_if = 32'h00400000; tick(); tick();
    pc_if = 32'h00400010; tick();
    stall = 1'b1; pc_if = 32'h00400000; tick(); tick();
    chk("stall2_bs_id", 32'(pred_bs_id), 32'h1);
    m0 = stat_miss;
    flush = 1'b1; tick();
    flush = 1'b0; stall = 1'b0;
    chk("flush_bs_ex", 32'(pred_bs_ex), 32'h0);
    chk("flush_bs_id", 32'(pred_bs_id), 32'h0);
    chk("flush_tgt_ex", pred_tgt_ex, 32'h0);
    chk("stat_miss_inc", stat_miss - m0, exp_d);
    tick();
    chk("post_flush_bs_ex", 32'(pred_bs_ex), 32'h0);

    pc_if = 32'h00400010; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_bs_id", 32'(pred_bs_id), 32'h0);
    chk("midrst_miss", stat_miss, 32'h0);
    tick();
    chk("midrst_bs_ex", 32'(pred_bs_ex), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btb_lookup.md
# btb_lookup

Fetch-side reader of the eight-entry branch prediction cache that the next-PC/update logic writes. Each cycle it matches the fetch PC against the cache tag array and produces the predicted next fetch PC. It carries the taken prediction and predicted target down an IF/ID and ID/EX pipeline so that `pred_bs_ex` reaches the execute stage aligned with the resolving branch, and serves as the `prediect_bs` input there. Sits between the PC register and instruction memory.

## Interface
- `ENTRIES`, 8: cache entries; fixed at 8 to match the update side.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pc_if` input 32: current fetch PC.
- `valid_i` input 8: entry valid bits; bit i is entry i+1 (v1..v8).
- `tag_i` input 256: entry source PCs; bits [32i+31:32i] are entry i+1 (A1..A8).
- `tgt_i` input 256: entry branch targets, same packing (B1..B8).
- `state_i` input 16: 2-bit saturating counters; bits [2i+1:2i] are entry i+1 (s1..s8).
- `stall` input 1: hold IF/ID and ID/EX contents.
- `flush` input 1: misprediction redirect (BandJ); kill in-flight predictions.
- `pred_pc` output 32: predicted next fetch PC (combinational).
- `pred_hit` output 1: `pc_if` matched a valid entry (combinational).
- `pred_bs_id` output 1: registered taken prediction, ID stage.
- `pred_bs_ex` output 1: registered taken prediction, EX stage.
- `pred_tgt_ex` output 32: registered predicted target, EX stage.
- `stat_lookups`, `stat_hits`, `stat_miss` output 32 each: statistics counters (see Configuration).

## Operation
- Match: entry i hits when `valid_i[i]` is set, its tag equals `pc_if`, and `pc_if[1:0]==2'b00`. A misaligned PC never hits.
- Multiple hits: the lowest index wins, and only that entry supplies target and state.
- Taken = hit && counter[1]. States 2'b10 and 2'b11 predict taken; 2'b00 and 2'b01 predict not taken.
- `pred_pc` = taken ? selected target : `pc_if + 32'h4`. The add is 32-bit and wraps at 0xFFFFFFFC→0x00000000.
- Pipeline registers:
  - IF/ID holds {taken, target}.
  - ID/EX holds {taken, target}.
  - A not-taken slot holds target = `pc_if+4` of that fetch.
- Priority each edge: `rst` > `flush` > `stall` > advance.
  - `flush`: both stages clear to {0, 32'h0}. Flush with stall still clears.
  - `stall`: both stages hold.
  - Advance: IF/ID ← current lookup, ID/EX ← IF/ID.
- The block never writes the cache. Table updates arrive through the `*_i` inputs on the cycle after the update side commits them, and the next lookup uses the new values.

## Timing
- `pred_pc` and `pred_hit`: zero-cycle combinational path from `pc_if` and the table inputs.
- `pred_bs_id`: 1 cycle after the fetch edge.
- `pred_bs_ex` and `pred_tgt_ex`: 2 cycles after, with no stalls. Each stall cycle adds one.
- Reset values:
  - `pred_bs_id`, `pred_bs_ex`: 0.
  - `pred_tgt_ex`: 32'h0.
  - All statistics counters: 0.
- During and after reset, `pred_pc` still follows `pc_if`, giving `pc_if+4` while the table is empty.
- Reset mid-stream discards in-flight predictions without waiting for resolution.

## Configuration
- `BTB_STATS_EN` defined: three 32-bit counters. They freeze at 32'hFFFFFFFF (saturate, no wrap) and are cleared by `rst`.
  - `stat_lookups`: increments on each non-stalled, non-flushed advance.
  - `stat_hits`: increments when that advance also has `pred_hit`.
  - `stat_miss`: increments on each cycle with `flush`.
- `BTB_STATS_EN` undefined: the ports remain and are tied to 32'h0. No counter logic is generated.

## Structure
- Shared package holds:
  - `BTB_ENTRIES` = 8.
  - Counter encodings `SNT`=2'b00, `WNT`=2'b01, `WT`=2'b10, `ST`=2'b11.
  - A pipeline-slot typedef {taken, target[31:0]} used by both stages.
- One sub-module, `btb_match`: a combinational 8-way compare plus priority select returning {hit, index, target, state}. The top level holds the pipeline registers and counters.

## Test plan
- Reset, then `pc_if`=0x00400000 with all valid bits 0 → `pred_pc`=0x00400004, `pred_hit`=0, and `pred_bs_ex`=0 two cycles later.
- Entry 3: valid, tag 0x00400010, target 0x00400040, state 2'b11. `pc_if`=0x00400010 → `pred_pc`=0x00400040 same cycle, `pred_bs_id`=1 at +1, `pred_bs_ex`=1 and `pred_tgt_ex`=0x00400040 at +2.
- Same entry with state 2'b01 → `pred_hit`=1, `pred_pc`=0x00400014, `pred_bs_ex`=0.
- Entries 2 and 6 both tagged 0x00400020, targets 0x100 and 0x200, both state 2'b10 → `pred_pc`=0x100.
- Taken prediction in IF/ID. Assert `stall` 2 cycles, then `flush` together with `stall` → `pred_bs_ex`=0 next cycle. `stat_miss` increments by 1 only with `BTB_STATS_EN`.
- `pc_if`=0xFFFFFFFC on a miss → `pred_pc`=0x00000000. `pc_if`=0x00400012 matching a tag → `pred_hit`=0.
